// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types; pipeline_ctrl optionally adds perf counters when PIPE_CTRL_PERF_EN is defined.
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} pctrl_state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_DRen,
  input  regbits_t idex_RegDest,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);
  assign load_use = idex_DRen && idex_RegDest != '0 &&
                    (idex_RegDest == ifid_rs || idex_RegDest == ifid_rt);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline stall/flush/halt control; PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemREN_m,
  input  logic        dmemWEN_m,
  input  logic        branch_taken_m,
  input  logic        jump_m,
  input  logic        halt_m,
  input  logic        idex_DRen,
  input  regbits_t    idex_RegDest,
  input  regbits_t    ifid_rs,
  input  regbits_t    ifid_rt,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        halt
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  pctrl_state_t state, nxt;
  logic pend, r_halt, r_redir, load_use;
  hazard_detect u_hazard (
    .idex_DRen(idex_DRen), .idex_RegDest(idex_RegDest),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .load_use(load_use)
  );
  // In MEMWAIT the access is still outstanding until dhit, whatever MEM reports.
  assign pend    = (state == MEMWAIT) ? !dhit : (dmemREN_m | dmemWEN_m) & !dhit;
  assign r_halt  = halt_m & !pend;
  assign r_redir = !r_halt & !pend & (branch_taken_m | jump_m);
  assign halt    = state == HALTED;
  // {pc_en, pc_redirect, ifid en/flush, idex en/flush, exmem en/flush, memwb en/flush}
  assign {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
          exmem_en, exmem_flush, memwb_en, memwb_flush} =
    (!nRST || halt) ? 10'b00_01_01_01_01 :
    r_halt          ? 10'b00_01_01_01_10 :
    pend            ? 10'b00_00_00_00_01 :
    r_redir         ? 10'b11_01_01_01_10 :
    load_use        ? 10'b00_00_01_10_10 :
    !ihit           ? 10'b00_01_10_10_10 :
                      10'b10_10_10_10_10;
  assign nxt = (halt || r_halt) ? HALTED : pend ? MEMWAIT : RUN;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= RUN;
    else state <= nxt;
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!halt && !pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (!halt && r_redir && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
`endif
endmodule
